// File: rtl/ysyx_idu_iq.sv
// Decode-side instruction queue with scoreboard/forwarding issue gate.
// Optional feature: define YSYX_IDU_IQ_BYPASS_EN to present an empty queue's incoming entry combinationally.
module ysyx_idu_iq #(
    parameter int BIT_W  = 32,
    parameter int DEPTH  = 4,
    parameter int FWD_N  = 2,
    parameter int RIDX_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    prev_valid,
    input  logic [31:0]             inst,
    input  logic [BIT_W-1:0]        pc,
    input  logic                    speculation,
    output logic                    ready_o,
    input  logic                    flush,
    input  logic [(1<<RIDX_W)-1:0]  rf_table,
    input  logic [FWD_N-1:0]        fwd_valid,
    input  logic [FWD_N*RIDX_W-1:0] fwd_rd,
    input  logic [FWD_N*BIT_W-1:0]  fwd_data,
    output logic [RIDX_W-1:0]       rs1_o,
    output logic [RIDX_W-1:0]       rs2_o,
    input  logic [BIT_W-1:0]        rdata1,
    input  logic [BIT_W-1:0]        rdata2,
    output logic                    valid_o,
    input  logic                    next_ready,
    output logic [31:0]             inst_o,
    output logic [BIT_W-1:0]        pc_o,
    output logic                    speculation_o,
    output logic [BIT_W-1:0]        rs1v_o,
    output logic [BIT_W-1:0]        rs2v_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [31:0]             stall_cnt_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;

    function automatic logic fwd_hit(input logic [RIDX_W-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < FWD_N; k++)
            if (fwd_valid[k] && fwd_rd[k*RIDX_W +: RIDX_W] == idx) hit = 1'b1;
        return hit;
    endfunction

    // Walk channels high to low so the lowest-index match is the one that sticks.
    function automatic logic [BIT_W-1:0] resolve(input logic [RIDX_W-1:0] idx,
                                                 input logic [BIT_W-1:0]  rdata);
        logic [BIT_W-1:0] r;
        r = rdata;
        for (int k = FWD_N - 1; k >= 0; k--)
            if (fwd_valid[k] && fwd_rd[k*RIDX_W +: RIDX_W] == idx) r = fwd_data[k*BIT_W +: BIT_W];
        return (idx == '0) ? '0 : r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    logic [31:0]      inst_mem [DEPTH];
    logic [BIT_W-1:0] pc_mem   [DEPTH];
    logic [DEPTH-1:0] spec_mem;
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic [31:0]      stall_cnt;

    logic             bypass, present, hazard, fire, enq, deq;
    logic             busy1, busy2, uses_rs2, no_src;
    logic [31:0]      cur_inst;
    logic [BIT_W-1:0] cur_pc;
    logic             cur_spec;
    logic [6:0]       opcode;

`ifdef YSYX_IDU_IQ_BYPASS_EN
    assign bypass = (count == '0) && prev_valid;
`else
    assign bypass = 1'b0;
`endif

    assign present = (count != '0) || bypass;

    always_comb begin
        cur_inst = '0;
        cur_pc   = '0;
        cur_spec = 1'b0;
        if (bypass) begin
            cur_inst = inst;
            cur_pc   = pc;
            cur_spec = speculation;
        end else if (count != '0) begin
            cur_inst = inst_mem[head];
            cur_pc   = pc_mem[head];
            cur_spec = spec_mem[head];
        end
    end

    assign opcode   = cur_inst[6:0];
    assign rs1_o    = cur_inst[15 +: RIDX_W];
    assign rs2_o    = cur_inst[20 +: RIDX_W];
    assign no_src   = (opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL);
    assign uses_rs2 = (opcode == OP_B) || (opcode == OP_S) || (opcode == OP_R);
    assign busy1    = (rs1_o != '0) && rf_table[rs1_o] && !fwd_hit(rs1_o);
    assign busy2    = (rs2_o != '0) && rf_table[rs2_o] && !fwd_hit(rs2_o);
    assign hazard   = present && !no_src && (busy1 || (uses_rs2 && busy2));

    assign valid_o       = present && !hazard;
    assign ready_o       = (count != CNT_W'(DEPTH));
    assign fire          = valid_o && next_ready;
    assign deq           = fire && (count != '0);
    // A bypassed instruction the decoder takes this cycle never lands in storage.
    assign enq           = prev_valid && ready_o && !(fire && bypass);

    assign inst_o        = cur_inst;
    assign pc_o          = cur_pc;
    assign speculation_o = cur_spec;
    assign rs1v_o        = resolve(rs1_o, rdata1);
    assign rs2v_o        = resolve(rs2_o, rdata2);
    assign count_o       = count;
    assign stall_cnt_o   = stall_cnt;

    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[tail] <= inst;
            pc_mem[tail]   <= pc;
            spec_mem[tail] <= speculation;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         stall_cnt <= '0;
        else if (hazard) stall_cnt <= sat_inc(stall_cnt);
    end
endmodule
